// File: rtl/turbo_deitl.sv
// rtl/turbo_deitl.sv - Turbo channel deinterleaver: symbols are written at (k*S) mod L and then read back in natural order.
module turbo_deitl (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] pb_size,
   input  logic [1:0] din,
   input  logic       din_vld,
   output logic       din_rdy,
   output logic [1:0] dout,
   output logic       dout_vld,
   output logic       dout_last
);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t      state, state_nxt;
   logic [11:0] blk_len, blk_step;
   logic [11:0] sel_len, sel_step;
   logic [11:0] waddr, wcnt, rcnt;
   logic [11:0] addr_sum, addr_wrap, wr_addr;
   logic        accept, rd_en, rd_final;
   logic [1:0]  mem [0:2079];

   always_comb begin
      sel_len  = 12'd2080;
      sel_step = 12'd33;
      case (pb_size)
         2'd0: begin sel_len = 12'd64;  sel_step = 12'd13; end
         2'd1: begin sel_len = 12'd544; sel_step = 12'd41; end
         default: begin sel_len = 12'd2080; sel_step = 12'd33; end
      endcase
   end

   // addr + S is below 2L, so one conditional subtraction keeps it in range
   assign addr_sum  = waddr + blk_step;
   assign addr_wrap = (addr_sum >= blk_len) ? addr_sum - blk_len : addr_sum;

   assign din_rdy  = !rst && (state != READ);
   assign accept   = din_vld && din_rdy;
   assign wr_addr  = (state == IDLE) ? 12'd0 : waddr;
   assign rd_en    = (state == READ);
   assign rd_final = (rcnt == blk_len - 12'd1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = (sel_len == 12'd1) ? READ : WRITE;
         WRITE: if (accept && wcnt == 12'd1) state_nxt = READ;
         READ:  if (rd_final) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         blk_len   <= '0;
         blk_step  <= '0;
         waddr     <= '0;
         wcnt      <= '0;
         rcnt      <= '0;
         dout_vld  <= 1'b0;
         dout_last <= 1'b0;
      end else begin
         state     <= state_nxt;
         dout_vld  <= rd_en;
         dout_last <= rd_en && rd_final;
         case (state)
            IDLE: if (accept) begin
               // block geometry is frozen here for the rest of the block
               blk_len  <= sel_len;
               blk_step <= sel_step;
               waddr    <= sel_step;
               wcnt     <= sel_len - 12'd1;
               rcnt     <= '0;
            end
            WRITE: if (accept) begin
               waddr <= addr_wrap;
               wcnt  <= wcnt - 12'd1;
            end
            READ: rcnt <= rd_final ? 12'd0 : rcnt + 12'd1;
            default: ;
         endcase
      end
   end

   // RAM array carries no reset; only the read output register is cleared
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_addr] <= din;
      if (rst)
         dout <= '0;
      else if (rd_en)
         dout <= mem[rcnt];
   end

endmodule

// File: doc/turbo_deitl.md
TURBO_DEITL -- requirements
Module: turbo_deitl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pb_size, input, 2 bits: PB size select (0=PB16, 1=PB136, 2=PB520, 3=reserved, treated as PB520).
REQ-004 SHALL have port din, input, 2 bits: one symbol (bit pair) in interleaved order.
REQ-005 SHALL have port din_vld, input, 1 bit: din valid.
REQ-006 SHALL have port din_rdy, output, 1 bit: block can accept din this cycle.
REQ-007 SHALL have port dout, output, 2 bits: deinterleaved symbol in natural order.
REQ-008 SHALL have port dout_vld, output, 1 bit: dout valid.
REQ-009 SHALL have port dout_last, output, 1 bit: marks the final symbol of a block; only high together with dout_vld.

Function
REQ-010 SHALL use block length L and step S per pb_size: PB16 L=64, S=13; PB136 L=544, S=41; PB520 L=2080, S=33.
REQ-011 SHALL map interleaved index k to natural address pi(k) = (k*S) mod L, so pi(0)=0.
REQ-012 SHALL generate pi(k) incrementally: addr_next = addr+S, minus L when the sum is >= L, using a single subtraction and a 12-bit address.
REQ-013 SHALL contain an internal 2080x2-bit RAM with one synchronous write port and one synchronous read port, 1-cycle read latency.
REQ-014 SHALL implement FSM states IDLE, WRITE and READ.
REQ-015 IDLE: din_rdy=1; on din_vld, SHALL accept the symbol, latch L and S from pb_size, write din to address 0, and go to WRITE (or to READ if L-1 writes remain is 0, which never occurs).
REQ-016 WRITE: din_rdy=1; each cycle with din_vld SHALL write din to pi(k) and advance k; cycles without din_vld SHALL leave state, address and count unchanged.
REQ-017 SHALL enter READ on the cycle after the L-th symbol is accepted.
REQ-018 SHALL ignore pb_size changes after the first symbol of a block until the block returns to IDLE.
REQ-019 READ: din_rdy=0 and din_vld ignored; read cycle r (r=0..L-1) SHALL issue read address r.
REQ-020 After read cycle L-1, the FSM SHALL go to IDLE.
REQ-021 dout_vld SHALL be asserted in the cycle after each read issue, giving L consecutive valid cycles.
REQ-022 The first dout SHALL appear 2 cycles after the last write is accepted.
REQ-023 dout_last SHALL be high with the L-th dout, which falls in the first IDLE cycle.
REQ-024 In that first IDLE cycle, a new din SHALL be accepted without disturbing the final dout.
REQ-025 Throughput SHALL be one block per L accepted writes plus L read cycles, with no extra bubble.
REQ-026 dout SHALL hold its last value when dout_vld=0.

Reset
REQ-027 When rst=1 at a clock edge, SHALL set state=IDLE, all counters and addresses to 0, dout=0, dout_vld=0 and dout_last=0.
REQ-028 During rst=1, din_rdy SHALL be 0; it SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-WRITE or mid-READ SHALL discard the partial block; no further dout_vld for that block.
REQ-030 RAM contents SHALL NOT be cleared by reset; reset SHALL NOT be required to initialise the RAM.

Verification
REQ-031 PB16, din_vld held high, symbol k = pi(k) mod 4 (write addresses 0,13,26,39,52,1,...) -> dout sequence 0,1,2,3,0,... for 64 cycles; dout_last only on the 64th; first dout_vld 2 cycles after the 64th accept.
REQ-032 PB136 and PB520 with random data, compared against a model of REQ-011 -> exact match over 544 and 2080 symbols, dout_vld contiguous.
REQ-033 PB16 with din_vld toggled 1,0,1,0 and din_vld=1 held throughout READ -> output identical to REQ-031; din_rdy=0 for all 64 READ cycles; no extra writes.
REQ-034 Back-to-back blocks PB16 then PB136 (pb_size changed mid-block and set at the next first symbol) -> first block output uses L=64; second block accepted in the dout_last cycle and output uses L=544.
REQ-035 rst pulsed after 30 PB16 symbols, then a full PB16 block -> no dout_vld from the aborted block; second block output correct.
REQ-036 pb_size=3 -> behaviour identical to pb_size=2 (2080 symbols out).
